// File: rtl/uvmt_apb_st_dut_pkg.sv
// Shared types, constants and address checking for the APB memory completer.
package uvmt_apb_st_dut_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } apb_state_e;

  localparam logic [3:0] LFSR_SEED = 4'b1001;
  // x^4 + x^3 + 1: feedback from the two most significant stages
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic addr_is_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/uvmt_apb_st_dut_lfsr.sv
// 4-bit Fibonacci LFSR with advance enable, used to pick pseudo-random wait counts.
module uvmt_apb_st_dut_lfsr
  import uvmt_apb_st_dut_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [3:0] value
);

  logic [3:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/uvmt_apb_st_dut_mem.sv
// APB4 completer backed by a word-addressed register memory with registered responses.
// Define UVMT_APB_ST_DUT_MEM_WAIT_STATES_EN to insert 0..3 pseudo-random wait states.
module uvmt_apb_st_dut_mem
  import uvmt_apb_st_dut_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  apb_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  setup;
  logic                  complete;
  logic [1:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic                  resp_write;
  logic                  resp_err;
  logic [IDX_W-1:0]      resp_idx;
  logic                  do_write;

  assign setup = (state_q == StIdle) && psel && !penable;

`ifdef UVMT_APB_ST_DUT_MEM_WAIT_STATES_EN
  logic [3:0] lfsr_value;

  uvmt_apb_st_dut_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (setup),
    .value   (lfsr_value)
  );

  assign wait_cnt = lfsr_value[1:0];
`else
  assign wait_cnt = 2'd0;
`endif

  // A zero-wait completion is registered on the setup edge, before the capture regs load.
  assign resp_addr  = (state_q == StIdle) ? paddr : addr_q;
  assign resp_write = (state_q == StIdle) ? pwrite : write_q;
  assign resp_err   = addr_is_err(32'(resp_addr), DEPTH);
  assign resp_idx   = resp_addr[IDX_W+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    complete  = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (setup) begin
          if (wait_cnt == 2'd0) begin
            state_d  = StDone;
            complete = 1'b1;
          end else begin
            state_d = StAccess;
            cnt_d   = wait_cnt - 2'd1;
          end
        end
      end
      StAccess: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d  = StDone;
          complete = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (complete) begin
      pready_d  = 1'b1;
      pslverr_d = resp_err;
      prdata_d  = (resp_err || resp_write) ? '0 : mem_q[resp_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (setup) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
      end
    end
  end

  assign do_write = (state_q == StDone) && write_q && psel && penable &&
                    !addr_is_err(32'(addr_q), DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_write) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) begin
          mem_q[addr_q[IDX_W+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_uvmt_apb_st_dut_mem.sv
// Directed self-checking bench for uvmt_apb_st_dut_mem (9-bit byte address, 64 words).
module tb_uvmt_apb_st_dut_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel;
  logic        penable;
  logic [8:0]  paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;
  int lfsr_idx = 0;

  uvmt_apb_st_dut_mem #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (9),
    .DEPTH      (64)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .psel    (psel),
    .penable (penable),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  always #5 clk = ~clk;

`ifdef UVMT_APB_ST_DUT_MEM_WAIT_STATES_EN
  // lfsr[1:0] along the sequence 1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,...
  int waits_tbl [15] = '{1, 3, 2, 1, 2, 1, 3, 3, 3, 2, 0, 0, 1, 2, 0};
`endif

  function automatic int next_waits();
    int w;
`ifdef UVMT_APB_ST_DUT_MEM_WAIT_STATES_EN
    w = waits_tbl[lfsr_idx];
`else
    w = 0;
`endif
    lfsr_idx = (lfsr_idx + 1) % 15;
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge, so calls chain back-to-back.
  task automatic apb_xfer(input string tag, input logic [8:0] addr, input logic wr,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic err);
    int n;
    int ew;
    ew      = next_waits();
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wd;
    pstrb   = st;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_waits"}, n, ew);
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    check_eq({tag, "_pready_once"}, {31'd0, pready}, 32'd0);
    check_eq({tag, "_prdata_idle"}, prdata, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          ew;
  logic        seen;

  initial begin
    reset   = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pwdata  = '0;
    pstrb   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_prdata", prdata, 32'd0);
    check_eq("rst_pready", {31'd0, pready}, 32'd0);
    check_eq("rst_pslverr", {31'd0, pslverr}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    apb_xfer("rd10", 9'h010, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd10_data", rd, 32'd0);
    check_eq("rd10_err", {31'd0, err}, 32'd0);

    // Byte-lane writes
    apb_xfer("wr04_full", 9'h004, 1'b1, 32'hDEADBEEF, 4'hF, rd, err);
    check_eq("wr04_full_err", {31'd0, err}, 32'd0);
    apb_xfer("wr04_b0", 9'h004, 1'b1, 32'h000000AA, 4'h1, rd, err);
    apb_xfer("rd04_a", 9'h004, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd04_a_data", rd, 32'hDEADBEAA);
    apb_xfer("wr04_mid", 9'h004, 1'b1, 32'h12345678, 4'b0110, rd, err);
    apb_xfer("wr04_nostrb", 9'h004, 1'b1, 32'hFFFFFFFF, 4'h0, rd, err);
    check_eq("wr04_nostrb_err", {31'd0, err}, 32'd0);
    apb_xfer("rd04_b", 9'h004, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd04_b_data", rd, 32'hDE3456AA);

    // Error responses
    apb_xfer("rd02", 9'h002, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd02_err", {31'd0, err}, 32'd1);
    check_eq("rd02_data", rd, 32'd0);
    apb_xfer("rd100", 9'h100, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd100_err", {31'd0, err}, 32'd1);
    check_eq("rd100_data", rd, 32'd0);
    apb_xfer("wr06", 9'h006, 1'b1, 32'h11111111, 4'hF, rd, err);
    check_eq("wr06_err", {31'd0, err}, 32'd1);
    apb_xfer("wr100", 9'h100, 1'b1, 32'h22222222, 4'hF, rd, err);
    check_eq("wr100_err", {31'd0, err}, 32'd1);
    apb_xfer("rd04_c", 9'h004, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd04_c_data", rd, 32'hDE3456AA);
    apb_xfer("rd00", 9'h000, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd00_data", rd, 32'd0);

    // Ten back-to-back reads; wait counts come from the table
    for (int i = 0; i < 10; i++) begin
      apb_xfer($sformatf("b2b%0d", i), 9'h004, 1'b0, 32'd0, 4'h0, rd, err);
      check_eq($sformatf("b2b%0d_data", i), rd, 32'hDE3456AA);
    end

    // Abort: psel drops right after setup
    apb_xfer("wr0c", 9'h00C, 1'b1, 32'h0BADF00D, 4'hF, rd, err);
    ew      = next_waits();
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = 9'h00C;
    pwrite  = 1'b1;
    pwdata  = 32'h12345678;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    psel    = 1'b0;
    pwrite  = 1'b0;
    check_eq("abort_t1_pready", {31'd0, pready}, {31'd0, ew == 0});
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | pready;
    end
    check_eq("abort_no_pready", {31'd0, seen}, 32'd0);
    apb_xfer("rd0c", 9'h00C, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd0c_data", rd, 32'h0BADF00D);
    check_eq("rd0c_err", {31'd0, err}, 32'd0);

    // Reset in the middle of a write
    apb_xfer("wr08", 9'h008, 1'b1, 32'hCAFEF00D, 4'hF, rd, err);
    apb_xfer("rd08_a", 9'h008, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd08_a_data", rd, 32'hCAFEF00D);
    ew      = next_waits();
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = 9'h008;
    pwrite  = 1'b1;
    pwdata  = 32'h55555555;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_pready", {31'd0, pready}, 32'd0);
    check_eq("midrst_prdata", prdata, 32'd0);
    check_eq("midrst_pslverr", {31'd0, pslverr}, 32'd0);
    @(posedge clk); #1;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    reset    = 1'b0;
    lfsr_idx = 0;
    @(posedge clk); #1;
    apb_xfer("rd08_b", 9'h008, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd08_b_data", rd, 32'd0);
    apb_xfer("rd04_d", 9'h004, 1'b0, 32'd0, 4'h0, rd, err);
    check_eq("rd04_d_data", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
